// File: rtl/ams_adc_sampler.sv
// -----------------------------------------------------------------------------
// ams_adc_sampler
//
// Consumer of a 1-bit AMS comparator. For each conversion it drives the
// comparator threshold select, waits for the analog front end to settle,
// counts '1' samples over a fixed window and presents {sel, count} on a
// valid/ready output backed by a single-entry holding register.
//
// Build option:
//   AMS_ADC_SAMPLER_SYNC_EN  defined   : comparator bit goes through a 2-flop
//                                        synchronizer (asynchronous source).
//                            undefined : comparator bit goes through a single
//                                        register (clk_i-synchronous source).
//
// Parameters:
//   SEL_W       width of the threshold select
//   WIN_LEN     accumulation window in cycles (>= 1)
//   SETTLE_CYC  settle wait after a select change (>= 1, >= 2 with sync)
//   CNT_W       width of the count, holds WIN_LEN without wrapping
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   start_i        single-cycle conversion request, honoured only when idle
//   continuous_i   1: start the next window back-to-back after each result
//   sel_cfg_i      requested threshold select
//   sel_o          threshold select driven to the comparator
//   adc_bit_i      comparator output
//   busy_o         high whenever a conversion is in progress
//   smp_valid_o    result valid
//   smp_ready_i    result consumed when valid and ready are both high
//   smp_cnt_o      number of '1' samples in the window
//   smp_sel_o      select value used for the window
//   overrun_o      sticky: an unconsumed result was overwritten
//   clr_overrun_i  clears overrun_o (a simultaneous new overrun wins)
// -----------------------------------------------------------------------------
module ams_adc_sampler #(
    parameter int  SEL_W      = 2,
    parameter int  WIN_LEN    = 255,
    parameter int  SETTLE_CYC = 4,
    localparam int CNT_W      = $clog2(WIN_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             continuous_i,
    input  logic [SEL_W-1:0] sel_cfg_i,
    output logic [SEL_W-1:0] sel_o,
    input  logic             adc_bit_i,
    output logic             busy_o,
    output logic             smp_valid_o,
    input  logic             smp_ready_i,
    output logic [CNT_W-1:0] smp_cnt_o,
    output logic [SEL_W-1:0] smp_sel_o,
    output logic             overrun_o,
    input  logic             clr_overrun_i
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_LEN - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM
    } state_t;

    state_t           state;
    logic [SET_W-1:0] settle_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] acc;
    logic             b_s;
    logic             win_done;
    logic             handshake;

    // -------------------------------------------------------------------------
    // Comparator sampling
    // -------------------------------------------------------------------------
`ifdef AMS_ADC_SAMPLER_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // Two-flop synchronizer: the comparator toggles independently of clk_i,
    // so the first flop may go metastable and is never used directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= adc_bit_i;
            sync_q2 <= sync_q1;
        end
    end

    assign b_s = sync_q2;
`else
    logic samp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_q <= 1'b0;
        end else begin
            samp_q <= adc_bit_i;
        end
    end

    assign b_s = samp_q;
`endif

    assign win_done  = (state == ACCUM) && (win_cnt == WIN_LAST);
    assign handshake = smp_valid_o && smp_ready_i;

    // -------------------------------------------------------------------------
    // Conversion FSM. SETTLE holds for SETTLE_CYC+1 edges so that the first
    // result appears 1+SETTLE_CYC+WIN_LEN edges after start is sampled; the
    // same holds after a select change at a window end in continuous mode.
    // -------------------------------------------------------------------------
    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; a blocking = would let later statements see
    // this cycle's new value and silently change the pipeline timing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            sel_o      <= '0;
            busy_o     <= 1'b0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            acc        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sel_o      <= sel_cfg_i;
                        settle_cnt <= '0;
                        busy_o     <= 1'b1;
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        win_cnt <= '0;
                        acc     <= '0;
                        state   <= ACCUM;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end

                ACCUM: begin
                    if (win_done) begin
                        // The result register captures acc + b_s on this edge.
                        win_cnt <= '0;
                        acc     <= '0;
                        if (!continuous_i) begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else if (sel_cfg_i != sel_o) begin
                            sel_o      <= sel_cfg_i;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end else begin
                        win_cnt <= win_cnt + CNT_W'(1);
                        acc     <= acc + CNT_W'(b_s);
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Single-entry result holding register. Never back-pressures the FSM: a
    // result that finds the register still full overwrites it and flags an
    // overrun. A load on the handshake edge keeps valid high with new data.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smp_valid_o <= 1'b0;
            smp_cnt_o   <= '0;
            smp_sel_o   <= '0;
            overrun_o   <= 1'b0;
        end else begin
            if (win_done) begin
                smp_valid_o <= 1'b1;
                smp_cnt_o   <= acc + CNT_W'(b_s);
                smp_sel_o   <= sel_o;
            end else if (handshake) begin
                smp_valid_o <= 1'b0;
            end

            // Set is written last so it wins over a same-edge clear.
            if (clr_overrun_i) begin
                overrun_o <= 1'b0;
            end
            if (win_done && smp_valid_o && !smp_ready_i) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule
